// File: rtl/pwm_capture_if.sv
// ---------------------------------------------------------------------------
// pwm_capture_if
//   Bundle between the motor PWM capture block and its consumer.
//   mot_pwm : raw motor PWM line (asynchronous to clk)
//   duty    : last accepted duty, 0..90
//   mot_rpm : decoded motor RPM
//   valid   : one-cycle strobe when duty/mot_rpm update
//   per_err : last completed period was out of tolerance (sticky)
//   stuck   : no edge seen for the timeout window
//   master  : the capture block (samples mot_pwm, drives the results)
//   slave   : the consumer / line driver (drives mot_pwm, reads the results)
// ---------------------------------------------------------------------------
interface pwm_capture_if;
  logic        mot_pwm;
  logic [6:0]  duty;
  logic [15:0] mot_rpm;
  logic        valid;
  logic        per_err;
  logic        stuck;

  modport master (input mot_pwm, output duty, mot_rpm, valid, per_err, stuck);
  modport slave  (output mot_pwm, input duty, mot_rpm, valid, per_err, stuck);
endinterface

// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//   Receive-side decoder for the 4 kHz motor PWM line, sampled at the 400 kHz
//   system clock. Measures high time and period in clocks, checks the period
//   against nominal, and reports duty (0..90) plus the equivalent motor RPM.
//
//   Ports
//     clk    : system clock
//     resetn : asynchronous active-low reset
//     cap    : pwm_capture_if.master (mot_pwm in; duty, mot_rpm, valid,
//              per_err, stuck out)
//
//   Parameters
//     PERIOD_CNT : nominal period in clocks
//     PERIOD_TOL : accepted +/- deviation of the measured period
//     TIMEOUT    : clocks without an edge before the line is stuck (1..255)
//
//   Build option
//     PWM_CAPTURE_FILTER_EN : when defined, a 3-sample glitch filter follows
//     the synchronizer (ignores 1-2 cycle pulses/gaps, adds 2 clk latency).
// ---------------------------------------------------------------------------
module pwm_capture #(
  parameter int PERIOD_CNT = 100,
  parameter int PERIOD_TOL = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          resetn,
  pwm_capture_if.master cap
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIGH  = 2'd1;
  localparam logic [1:0] ST_LOW   = 2'd2;
  localparam logic [1:0] ST_STUCK = 2'd3;

  localparam logic [7:0] IDLE_MAX   = 8'(TIMEOUT);
  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);
  localparam logic [8:0] PER_MIN    = 9'(PERIOD_CNT - PERIOD_TOL);
  localparam logic [8:0] PER_MAX    = 9'(PERIOD_CNT + PERIOD_TOL);
  localparam logic [7:0] DUTY_MAX   = 8'd90;
  localparam logic [7:0] CNT_MAX    = 8'hFF;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic sync_q1, sync_q2;
  logic lvl, lvl_q;
  logic edge_det, rise_det, fall_det;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= cap.mot_pwm;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic hist1, hist2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist1 <= 1'b0;
      hist2 <= 1'b0;
    end else begin
      hist1 <= sync_q2;
      hist2 <= hist1;
    end
  end

  // The filtered level only follows the line once three consecutive
  // synchronized samples agree; otherwise it holds its previous value.
  assign lvl = (sync_q2 == hist1 && hist1 == hist2) ? sync_q2 : lvl_q;
`else
  assign lvl = sync_q2;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lvl_q <= 1'b0;
    else         lvl_q <= lvl;
  end

  assign edge_det = lvl ^ lvl_q;
  assign rise_det = edge_det & lvl;
  assign fall_det = edge_det & ~lvl;

  // -------------------------------------------------------------------------
  // Measurement FSM and counters
  // -------------------------------------------------------------------------
  logic [1:0] state;
  logic [7:0] hi_cnt, per_cnt, idle_cnt;
  logic       skip_eval;   // period began from STUCK via a falling edge
  logic       timeout;
  logic       eval_go;
  logic [8:0] eval_per;
  logic [7:0] eval_hi;

  // An edge in the same cycle as the timeout wins; STUCK never re-times out.
  assign timeout = !edge_det && (idle_cnt == IDLE_LIMIT) && (state != ST_STUCK);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      hi_cnt    <= 8'd0;
      per_cnt   <= 8'd0;
      idle_cnt  <= 8'd0;
      skip_eval <= 1'b0;
      eval_go   <= 1'b0;
      eval_per  <= 9'd0;
      eval_hi   <= 8'd0;
    end else begin
      eval_go <= 1'b0;

      if (edge_det)                idle_cnt <= 8'd0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 8'd1;

      // NOTE: the counter clears in the case below are later non-blocking
      // assignments to the same registers, so they override these increments.
      if (per_cnt != CNT_MAX)                      per_cnt <= per_cnt + 8'd1;
      if (state == ST_HIGH && hi_cnt != CNT_MAX)   hi_cnt  <= hi_cnt + 8'd1;

      case (state)
        ST_IDLE: begin
          if (rise_det) begin
            state   <= ST_HIGH;
            hi_cnt  <= 8'd0;
            per_cnt <= 8'd0;
          end else if (timeout) begin
            state <= ST_STUCK;
          end
        end
        ST_HIGH: begin
          if (fall_det)      state <= ST_LOW;
          else if (timeout)  state <= ST_STUCK;
        end
        ST_LOW: begin
          if (rise_det) begin
            state     <= ST_HIGH;
            hi_cnt    <= 8'd0;
            per_cnt   <= 8'd0;
            eval_go   <= !skip_eval;
            eval_per  <= {1'b0, per_cnt} + 9'd1;
            eval_hi   <= hi_cnt;
            skip_eval <= 1'b0;
          end else if (timeout) begin
            state <= ST_STUCK;
          end
        end
        ST_STUCK: begin
          if (rise_det) begin
            state   <= ST_HIGH;
            hi_cnt  <= 8'd0;
            per_cnt <= 8'd0;
          end else if (fall_det) begin
            state     <= ST_LOW;
            skip_eval <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Evaluation and result registers
  // -------------------------------------------------------------------------
  logic        per_ok;
  logic [6:0]  new_duty;
  logic [15:0] duty_w, new_rpm;

  assign per_ok   = (eval_per >= PER_MIN) && (eval_per <= PER_MAX);
  assign new_duty = (eval_hi > DUTY_MAX) ? DUTY_MAX[6:0] : eval_hi[6:0];
  assign duty_w   = {9'd0, new_duty};
  // 61*duty + 500 built from a shift and small subtractions.
  assign new_rpm  = (duty_w << 6) - (duty_w << 1) - duty_w + 16'd500;

  logic [6:0]  duty_q;
  logic [15:0] rpm_q;
  logic        valid_q, per_err_q, stuck_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      duty_q    <= 7'd0;
      rpm_q     <= 16'd0;
      valid_q   <= 1'b0;
      per_err_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (timeout) begin
        // Motor reported stopped; stuck persists until an accepted period.
        stuck_q <= 1'b1;
        duty_q  <= 7'd0;
        rpm_q   <= 16'd0;
        valid_q <= 1'b1;
      end else if (eval_go) begin
        if (per_ok) begin
          duty_q    <= new_duty;
          rpm_q     <= new_rpm;
          per_err_q <= 1'b0;
          stuck_q   <= 1'b0;
          valid_q   <= 1'b1;
        end else begin
          per_err_q <= 1'b1;
        end
      end
    end
  end

  assign cap.duty    = duty_q;
  assign cap.mot_rpm = rpm_q;
  assign cap.valid   = valid_q;
  assign cap.per_err = per_err_q;
  assign cap.stuck   = stuck_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Motor PWM capture and decode block, the receive-side counterpart of the motor `pwm` generator. It samples a 4 kHz motor PWM line clocked at the 400 kHz system rate (100 clocks per nominal period). It measures high time and period in clock counts, checks the period against nominal, and reports duty (0–90) and the equivalent motor RPM. It sits on the motor feedback/monitor path, so the flight controller can close the loop on commanded versus actual drive.

## Interface

Parameters:
- `PERIOD_CNT`, 100: nominal PWM period in clk cycles.
- `PERIOD_TOL`, 2: accepted ± deviation of the measured period, in cycles.
- `TIMEOUT`, 255: cycles without an edge before the line is declared stuck. Must be ≤ 255.

Ports:
- `clk` input 1: system clock, 400 kHz nominal.
- `resetn` input 1: reset, asynchronous, active-low.
- `mot_pwm` input 1: PWM line, asynchronous to `clk`.
- `duty` output 7: last accepted duty, 0–90.
- `mot_rpm` output 16: decoded RPM.
- `valid` output 1: one-cycle strobe when `duty`/`mot_rpm` update.
- `per_err` output 1: last completed period was out of tolerance. Sticky until the next accepted period.
- `stuck` output 1: no edge for `TIMEOUT` cycles.

## Operation

Input conditioning:
- 2-flop synchronizer on `mot_pwm`.
- An edge is the synchronized level differing from its registered previous value.

Counters:
- `hi_cnt` and `per_cnt` are 8-bit and saturate at 255.
- `per_cnt` counts every cycle from a rising edge.
- `hi_cnt` counts only in HIGH.
- A single idle counter tracks cycles since the last edge.

FSM states: IDLE, HIGH, LOW, STUCK.
- IDLE: wait for a rising edge, then go to HIGH and clear the counters. Timeout → STUCK.
- HIGH: falling edge → LOW. Timeout → STUCK.
- LOW: rising edge ends the period, the measurement is evaluated, go to HIGH and clear the counters. Timeout → STUCK.
- STUCK: rising edge → HIGH and clear the counters. Falling edge → LOW without a measurement; the next rising edge does not evaluate and just restarts HIGH.

Evaluation at the period-ending rising edge (`P` = `per_cnt` + 1, `H` = `hi_cnt`):
- If |P − PERIOD_CNT| ≤ PERIOD_TOL:
  - `duty` = min(H, 90).
  - `mot_rpm` = 500 + 61·`duty`, computed as `duty`·64 − `duty`·3 + 500 in 16 bits. Maximum 5990.
  - `duty` = 0 is impossible in a valid period.
  - `per_err` ← 0, `stuck` ← 0, `valid` pulses.
- Otherwise: `per_err` ← 1, `duty`/`mot_rpm` hold, no `valid`.

Entering STUCK:
- `stuck` ← 1, `duty` ← 0, `mot_rpm` ← 0 (motor stopped), `valid` pulses once.
- `stuck` clears only on the next accepted period.

Simultaneous events: timeout and an edge in the same cycle → the edge wins, no stuck.

## Timing

- Reset values: `duty` 0, `mot_rpm` 0, `valid` 0, `per_err` 0, `stuck` 0, state IDLE, all counters 0.
- Reset mid-operation clears everything immediately. The first `valid` requires two rising edges after release.
- Edge detect latency: 3 clk from `mot_pwm` transition to FSM action without filter, 5 clk with filter.
- `valid`, `duty`, `mot_rpm`, `per_err` register 1 clk after the period-ending edge is detected: 4 clk (6 clk filtered) after the input rising edge. All change in the same cycle.
- `valid` is exactly one cycle wide. The minimum spacing between strobes is one period.
- `stuck` asserts on the cycle the idle counter reaches `TIMEOUT`, measured from the last detected edge.

## Configuration

- `PWM_CAPTURE_FILTER_EN` defined:
  - A glitch filter follows the synchronizer.
  - The filtered level changes only after 3 consecutive identical synchronized samples.
  - Pulses or gaps of 1–2 cycles are ignored.
  - Adds 2 clk latency.
- Undefined:
  - No filter; the synchronizer output drives edge detect directly.
  - Every synchronized transition is an edge.

## Test plan

- 40 high / 60 low, repeated 3 periods → first `valid` at the 2nd rising edge + 4 clk, `duty`=40, `mot_rpm`=2940, `per_err`=0. Then one `valid` per period.
- 95 high / 5 low → `duty`=90, `mot_rpm`=5990, `valid` pulses.
- After an accepted 30/70 period, send 50 high / 60 low (period 110) → `per_err`=1, no `valid`, `duty`=30 held. A following 30/70 period clears `per_err` and pulses `valid`.
- After a valid period, hold `mot_pwm` low 300 cycles → `stuck`=1 exactly 255 clk after the last detected edge, `duty`=0, `mot_rpm`=0, one `valid`. Then resume 20/80 → after the 2nd rising edge: `stuck`=0, `duty`=20, `mot_rpm`=1720.
- 50/50 periods with a 1-cycle low glitch at high-cycle 20:
  - With `PWM_CAPTURE_FILTER_EN` → `duty`=50, no `per_err`.
  - Without → `per_err`=1 on the affected period.
- Assert `resetn` low for 3 clk mid-HIGH during 40/60 traffic → all outputs 0 asynchronously. After release, no `valid` at the 1st rising edge; `valid` with `duty`=40 at the 2nd.
